// File: rtl/mc_pkg.sv
// mc_pkg: shared types and constants for the memory-controller front end.
// Holds the trace entry layout, the DDR4 address split and the command codes.
package mc_pkg;

   localparam int unsigned MC_ADDR_WIDTH  = 36;
   localparam int unsigned MC_MEMOP_WIDTH = 12;
   localparam int unsigned MC_TIME_WIDTH  = 12;

   // DDR4 field positions inside the raw trace address
   localparam int unsigned ROW_MSB   = 33;
   localparam int unsigned ROW_LSB   = 18;
   localparam int unsigned BANK_MSB  = 9;
   localparam int unsigned BANK_LSB  = 8;
   localparam int unsigned BG_MSB    = 7;
   localparam int unsigned BG_LSB    = 6;
   localparam int unsigned COLH_MSB  = 17;
   localparam int unsigned COLH_LSB  = 10;
   localparam int unsigned COLL_MSB  = 5;
   localparam int unsigned COLL_LSB  = 3;

   // Packed trace line as delivered by the parser: {time, cmd, addr}
   typedef struct packed {
      logic [MC_TIME_WIDTH-1:0]  tstamp;
      logic [MC_MEMOP_WIDTH-1:0] cmd;
      logic [MC_ADDR_WIDTH-1:0]  addr;
   } trace_entry_t;

   typedef struct packed {
      logic [15:0] row;
      logic [1:0]  bank;
      logic [1:0]  bg;
      logic [10:0] col;
   } ddr_addr_t;

   typedef enum logic [MC_MEMOP_WIDTH-1:0] {
      MC_CMD_READ   = 12'd0,
      MC_CMD_WRITE  = 12'd1,
      MC_CMD_IFETCH = 12'd2
   } mc_cmd_e;

endpackage

// File: rtl/ddr_addr_decode.sv
// ddr_addr_decode: purely combinational split of a trace address into DDR4
// row / bank / bank-group / column fields. Shared with the command scheduler.
module ddr_addr_decode
   import mc_pkg::*;
(
   input  logic [MC_ADDR_WIDTH-1:0]    addr_i,
   output logic [$bits(ddr_addr_t)-1:0] fields_o
);

   ddr_addr_t dec_s;
   logic      unused_addr_s;

   // Slice the address into its DDR4 fields; column is split around bank/bg
   always_comb begin
      dec_s      = '0;
      dec_s.row  = addr_i[ROW_MSB:ROW_LSB];
      dec_s.bank = addr_i[BANK_MSB:BANK_LSB];
      dec_s.bg   = addr_i[BG_MSB:BG_LSB];
      dec_s.col  = {addr_i[COLH_MSB:COLH_LSB], addr_i[COLL_MSB:COLL_LSB]};
   end

   // Top address bits and the byte offset do not map to any DDR4 field
   assign unused_addr_s = ^{addr_i[MC_ADDR_WIDTH-1:ROW_MSB+1], addr_i[COLL_LSB-1:0]};
   assign fields_o      = dec_s;

endmodule

// File: rtl/mc_request_queue.sv
// mc_request_queue: in-order trace request queue feeding the DRAM scheduler.
// Entries are released only when the CPU cycle count reaches their timestamp.
// Optional build macro MCQ_STATS_EN adds peak_count and stall_cycles outputs.
// Address widths must match mc_pkg (the decoder is built on those constants).
module mc_request_queue
   import mc_pkg::*;
#(
   parameter int DEPTH       = 16,
   parameter int ADDR_WIDTH  = MC_ADDR_WIDTH,
   parameter int MEMOP_WIDTH = MC_MEMOP_WIDTH,
   parameter int TIME_WIDTH  = MC_TIME_WIDTH
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic [63:0]                              cycle,
   input  logic                                     data_rdy,
   input  logic [TIME_WIDTH+MEMOP_WIDTH+ADDR_WIDTH-1:0] data_read,
   input  logic                                     shutdown,
   output logic                                     data_req,
   output logic                                     out_valid,
   input  logic                                     out_ready,
   output logic [MEMOP_WIDTH-1:0]                   out_cmd,
   output logic [ADDR_WIDTH-1:0]                    out_addr,
   output logic [15:0]                              out_row,
   output logic [1:0]                               out_bank,
   output logic [1:0]                               out_bg,
   output logic [10:0]                              out_col,
   output logic [$clog2(DEPTH):0]                   count,
   output logic                                     full,
   output logic                                     empty,
   output logic                                     overflow
`ifdef MCQ_STATS_EN
   ,
   output logic [$clog2(DEPTH):0]                   peak_count,
   output logic [31:0]                              stall_cycles
`endif
);

   localparam int PTR_W   = $clog2(DEPTH);
   localparam int CNT_W   = PTR_W + 1;
   localparam int ENTRY_W = TIME_WIDTH + MEMOP_WIDTH + ADDR_WIDTH;

   logic [ENTRY_W-1:0]     mem_q [DEPTH];
   logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]       count_q, count_d;
   logic                   full_q, full_d, empty_q, empty_d;
   logic                   overflow_q, overflow_d, data_req_q, data_req_d;
   logic                   push_s, pop_s, drop_s, out_valid_s;
   logic [TIME_WIDTH-1:0]  head_time_s;
   logic [MEMOP_WIDTH-1:0] head_cmd_s;
   logic [ADDR_WIDTH-1:0]  head_addr_s;
   ddr_addr_t              head_dec_s;
   logic [$bits(ddr_addr_t)-1:0] head_fields_s;

   // Head unpack, timestamp gate and handshake qualification
   always_comb begin
      {head_time_s, head_cmd_s, head_addr_s} = mem_q[rd_ptr_q];
      out_valid_s = !empty_q && (cycle >= 64'(head_time_s));
      pop_s       = out_valid_s && out_ready;
      // A pop in the same cycle frees the slot, so a full queue still accepts
      push_s      = data_rdy && (!full_q || pop_s);
      drop_s      = data_rdy && full_q && !pop_s;
   end

   // Next-state for pointers, occupancy and status flags
   always_comb begin
      wr_ptr_d = push_s ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop_s  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
      full_d     = (count_d == CNT_W'(DEPTH));
      empty_d    = (count_d == CNT_W'(0));
      overflow_d = overflow_q || drop_s;
      // Keep one slot spare for the line the parser already has in flight
      data_req_d = !shutdown && (count_d < CNT_W'(DEPTH - 1));
   end

   // State and storage registers; reset discards every queued entry
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         overflow_q <= 1'b0;
         data_req_q <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         full_q     <= full_d;
         empty_q    <= empty_d;
         overflow_q <= overflow_d;
         data_req_q <= data_req_d;
         if (push_s) begin
            mem_q[wr_ptr_q] <= data_read;
         end
      end
   end

   ddr_addr_decode u_decode (
      .addr_i   (head_addr_s),
      .fields_o (head_fields_s)
   );

   assign head_dec_s = ddr_addr_t'(head_fields_s);

   assign data_req  = data_req_q;
   assign out_valid = out_valid_s;
   assign out_cmd   = head_cmd_s;
   assign out_addr  = head_addr_s;
   assign out_row   = head_dec_s.row;
   assign out_bank  = head_dec_s.bank;
   assign out_bg    = head_dec_s.bg;
   assign out_col   = head_dec_s.col;
   assign count     = count_q;
   assign full      = full_q;
   assign empty     = empty_q;
   assign overflow  = overflow_q;

`ifdef MCQ_STATS_EN
   logic [CNT_W-1:0] peak_q;
   logic [31:0]      stall_q;

   // Occupancy high-water mark and saturating head-stall counter
   always_ff @(posedge clk) begin
      if (rst) begin
         peak_q  <= '0;
         stall_q <= '0;
      end else begin
         if (count_d > peak_q) begin
            peak_q <= count_d;
         end
         if (out_valid_s && !out_ready && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
         end
      end
   end

   assign peak_count   = peak_q;
   assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_mc_request_queue.sv
// tb_mc_request_queue: randomized and directed stimulus for mc_request_queue,
// checked every cycle against a queue-based behavioural model.
module tb_mc_request_queue;

   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] cycle;
   logic        data_rdy;
   logic [59:0] data_read;
   logic        shutdown;
   logic        out_ready;
   logic        data_req, out_valid, full, empty, overflow;
   logic [11:0] out_cmd;
   logic [35:0] out_addr;
   logic [15:0] out_row;
   logic [1:0]  out_bank, out_bg;
   logic [10:0] out_col;
   logic [4:0]  count;
`ifdef MCQ_STATS_EN
   logic [4:0]  peak_count;
   logic [31:0] stall_cycles;
`endif

   int checks = 0;
   int errors = 0;

   // Behavioural model state
   logic [59:0] mq[$];
   logic [59:0] issued[$];
   bit          m_ovf;
   bit          m_req;
   bit          armed = 1'b0;
   int          m_peak;
   longint      m_stall;

   always #5 clk = ~clk;

   mc_request_queue #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .cycle     (cycle),
      .data_rdy  (data_rdy),
      .data_read (data_read),
      .shutdown  (shutdown),
      .data_req  (data_req),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_cmd   (out_cmd),
      .out_addr  (out_addr),
      .out_row   (out_row),
      .out_bank  (out_bank),
      .out_bg    (out_bg),
      .out_col   (out_col),
      .count     (count),
      .full      (full),
      .empty     (empty),
      .overflow  (overflow)
`ifdef MCQ_STATS_EN
      ,
      .peak_count   (peak_count),
      .stall_cycles (stall_cycles)
`endif
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h (cycle=%0d)", name, act, exp, cycle);
      end
   endtask

   // Advance one clock; inputs change only after the edge
   task automatic tick();
      @(posedge clk);
      #1;
      cycle = cycle + 64'd1;
      #1;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      data_rdy  = 1'b0;
      out_ready = 1'b0;
      shutdown  = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Model: compare outputs mid-cycle, then apply this cycle's inputs
   always @(negedge clk) begin : model
      int          sz;
      bit          v;
      bit          pop;
      logic [59:0] h;
      logic [35:0] a;
      sz = mq.size();
      h  = (sz > 0) ? mq[0] : 60'd0;
      a  = h[35:0];
      v  = (sz > 0) && (cycle >= 64'(h[59:48]));
      if (armed) begin
         chk("count", 64'(count), 64'(sz));
         chk("empty", 64'(empty), 64'(sz == 0));
         chk("full", 64'(full), 64'(sz == DEPTH));
         chk("overflow", 64'(overflow), 64'(m_ovf));
         chk("data_req", 64'(data_req), 64'(m_req));
         chk("out_valid", 64'(out_valid), 64'(v));
         if (v) begin
            chk("out_cmd", 64'(out_cmd), 64'(h[47:36]));
            chk("out_addr", 64'(out_addr), 64'(a));
            chk("out_row", 64'(out_row), 64'((a >> 18) & 36'hFFFF));
            chk("out_bank", 64'(out_bank), 64'((a >> 8) & 36'h3));
            chk("out_bg", 64'(out_bg), 64'((a >> 6) & 36'h3));
            chk("out_col", 64'(out_col), 64'((((a >> 10) & 36'hFF) * 8) + ((a >> 3) & 36'h7)));
         end
`ifdef MCQ_STATS_EN
         chk("peak_count", 64'(peak_count), 64'(m_peak));
         chk("stall_cycles", 64'(stall_cycles), 64'(m_stall));
`endif
      end
      if (rst) begin
         mq.delete();
         issued.delete();
         m_ovf   = 1'b0;
         m_req   = 1'b0;
         m_peak  = 0;
         m_stall = 0;
         armed   = 1'b1;
      end else begin
         if (v && !out_ready && m_stall < 64'hFFFF_FFFF) m_stall++;
         pop = v && out_ready;
         if (pop) issued.push_back(mq.pop_front());
         if (data_rdy) begin
            if (sz < DEPTH || pop) mq.push_back(data_read);
            else m_ovf = 1'b1;
         end
         m_req = !shutdown && (mq.size() < DEPTH - 1);
         if (mq.size() > m_peak) m_peak = mq.size();
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int n;
      int budget;
      rst       = 1'b1;
      cycle     = 64'd0;
      data_rdy  = 1'b0;
      data_read = 60'd0;
      shutdown  = 1'b0;
      out_ready = 1'b0;

      // Reset: two cycles high
      tick();
      tick();
      chk("rst_empty", 64'(empty), 64'd1);
      chk("rst_data_req", 64'(data_req), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_full", 64'(full), 64'd0);
      chk("rst_overflow", 64'(overflow), 64'd0);
      chk("rst_out_addr", 64'(out_addr), 64'd0);
      rst = 1'b0;
      tick();
      chk("req_after_rst", 64'(data_req), 64'd1);

      // Timing gate: time=10 entry pushed at cycle 3
      cycle     = 64'd3;
      data_rdy  = 1'b1;
      data_read = {12'd10, 12'd0, 36'h1_2345_6789};
      tick();
      data_rdy = 1'b0;
      while (cycle < 64'd10) begin
         chk("gate_early", 64'(out_valid), 64'd0);
         tick();
      end
      chk("gate_on", 64'(out_valid), 64'd1);
      chk("gate_row", 64'(out_row), 64'h48D1);
      chk("gate_bank", 64'(out_bank), 64'd3);
      chk("gate_bg", 64'(out_bg), 64'd2);
      chk("gate_col", 64'(out_col), 64'h2C9);
      chk("gate_cmd", 64'(out_cmd), 64'd0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("gate_drained", 64'(empty), 64'd1);

      // Fill to full with out_ready low, then one dropped entry
      do_reset();
      cycle = 64'd0;
      for (int i = 0; i < 16; i++) begin
         if (i == 14) chk("req_at_14", 64'(data_req), 64'd1);
         if (i == 15) chk("req_at_15", 64'(data_req), 64'd0);
         data_rdy  = 1'b1;
         data_read = {12'hFFF, 12'd1, 36'(i)};
         tick();
      end
      chk("fill_full", 64'(full), 64'd1);
      chk("fill_count", 64'(count), 64'd16);
      chk("fill_req", 64'(data_req), 64'd0);
      chk("fill_no_ovf", 64'(overflow), 64'd0);
      data_read = {12'hFFF, 12'd1, 36'd99};
      tick();
      data_rdy = 1'b0;
      chk("drop_ovf", 64'(overflow), 64'd1);
      chk("drop_count", 64'(count), 64'd16);

      // Full queue with simultaneous push and pop
      do_reset();
      cycle = 64'd100;
      for (int i = 0; i < 16; i++) begin
         data_rdy  = 1'b1;
         data_read = {12'd0, 12'd2, 36'(i)};
         tick();
      end
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         data_read = {12'd0, 12'd2, 36'(100 + i)};
         tick();
         chk("pp_count", 64'(count), 64'd16);
         chk("pp_ovf", 64'(overflow), 64'd0);
      end
      data_rdy = 1'b0;
      budget   = 0;
      while (!empty && budget < 40) begin
         tick();
         budget++;
      end
      chk("pp_drained", 64'(empty), 64'd1);
      chk("pp_issued", 64'(issued.size()), 64'd24);
      for (int i = 0; i < 24 && i < issued.size(); i++) begin
         chk("pp_order", 64'(issued[i][35:0]), (i < 16) ? 64'(i) : 64'(100 + i - 16));
      end

      // Wrap/order: 40 entries, times 0..39, random handshakes
      do_reset();
      cycle  = 64'd0;
      n      = 0;
      budget = 0;
      while (issued.size() < 40 && budget < 3000) begin
         data_rdy = (n < 40) && (mq.size() < DEPTH - 1) && ($urandom_range(0, 3) != 0);
         if (data_rdy) begin
            data_read = {12'(n), 12'($urandom_range(0, 2)), 36'({$urandom(), $urandom()})};
            n++;
         end
         out_ready = ($urandom_range(0, 1) == 1);
         tick();
         budget++;
      end
      data_rdy  = 1'b0;
      out_ready = 1'b0;
      chk("wrap_issued", 64'(issued.size()), 64'd40);
      for (int i = 0; i < 40 && i < issued.size(); i++) begin
         chk("wrap_order", 64'(issued[i][59:48]), 64'(i));
      end

      // Reset mid-operation discards queued entries
      do_reset();
      for (int i = 0; i < 3; i++) begin
         data_rdy  = 1'b1;
         data_read = {12'hFFF, 12'd0, 36'(i)};
         tick();
      end
      data_rdy = 1'b0;
      chk("mid_count", 64'(count), 64'd3);
      do_reset();
      chk("mid_rst_empty", 64'(empty), 64'd1);
      chk("mid_rst_count", 64'(count), 64'd0);

      // Shutdown with five entries queued
      cycle = 64'd50;
      for (int i = 0; i < 5; i++) begin
         data_rdy  = 1'b1;
         data_read = {12'd0, 12'd1, 36'(i + 7)};
         tick();
      end
      data_rdy = 1'b0;
      shutdown = 1'b1;
      tick();
      chk("sd_req", 64'(data_req), 64'd0);
      chk("sd_count", 64'(count), 64'd5);
      out_ready = 1'b1;
      budget    = 0;
      while (!empty && budget < 20) begin
         tick();
         budget++;
      end
      out_ready = 1'b0;
      chk("sd_empty", 64'(empty), 64'd1);
      chk("sd_issued", 64'(issued.size()), 64'd5);
      chk("sd_req_low", 64'(data_req), 64'd0);
`ifdef MCQ_STATS_EN
      chk("sd_peak", 64'(peak_count), 64'd5);
`endif
      shutdown = 1'b0;
      tick();
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
